// File: rtl/alu_op_sequencer_if.sv
// Request/response channel between a command master and the ALU op sequencer.
// Latency: none (wires only).
// Backpressure: valid/ready on both channels; req_ready/rsp_valid are driven by the sequencer.
interface alu_op_sequencer_if #(
    parameter int W   = 16,
    parameter int OPW = 5
);
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [W-1:0]   req_x;
    logic [W-1:0]   req_y;
    logic [2:0]     req_jmp;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_zr;
    logic           rsp_ng;
    logic           rsp_jump;
    logic           rsp_err;

    modport master (
        output req_valid, req_op, req_x, req_y, req_jmp, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_jump, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, req_jmp, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_jump, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives the Hack ALU from encoded ops, captures out/zr/ng, evaluates the jump condition.
// Latency: response valid 2 edges after the request is presented (1 for illegal ops).
// Backpressure: req_ready only in IDLE; response held until rsp_ready. Optional ALU_SEQ_CHECK_EN adds a result checker.
module alu_op_sequencer #(
    parameter int W   = 16,
    parameter int OPW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic         alu_zx,
    output logic         alu_nx,
    output logic         alu_zy,
    output logic         alu_ny,
    output logic         alu_f,
    output logic         alu_no,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zr,
    input  logic         alu_ng
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           w_req_ready;
    logic           w_rsp_valid;
    logic           w_legal;
    logic           w_jump;
    logic           w_chk_err;

    logic [W-1:0]   r_x;
    logic [W-1:0]   r_y;
    logic [2:0]     r_jmp;
    logic [5:0]     r_ctl;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_zr;
    logic           r_rsp_ng;
    logic           r_rsp_jump;
    logic           r_rsp_err;

    // Op index -> {zx,nx,zy,ny,f,no}
    function automatic logic [5:0] f_decode(input logic [OPW-1:0] op);
        case (int'(op))
            0:       f_decode = 6'b101010;
            1:       f_decode = 6'b111111;
            2:       f_decode = 6'b111010;
            3:       f_decode = 6'b001100;
            4:       f_decode = 6'b110000;
            5:       f_decode = 6'b001101;
            6:       f_decode = 6'b110001;
            7:       f_decode = 6'b001111;
            8:       f_decode = 6'b110011;
            9:       f_decode = 6'b011111;
            10:      f_decode = 6'b110111;
            11:      f_decode = 6'b001110;
            12:      f_decode = 6'b110010;
            13:      f_decode = 6'b000010;
            14:      f_decode = 6'b010011;
            15:      f_decode = 6'b000111;
            16:      f_decode = 6'b000000;
            17:      f_decode = 6'b010101;
            default: f_decode = 6'b000000;
        endcase
    endfunction

    assign w_legal = (bus.req_op <= OPW'(17));

    // Flags seen during EXEC decide the jump; j1=lt, j2=eq, j3=gt
    assign w_jump = (r_jmp[2] & alu_ng) | (r_jmp[1] & alu_zr) | (r_jmp[0] & ~alu_ng & ~alu_zr);

`ifdef ALU_SEQ_CHECK_EN
    logic [OPW-1:0] r_op;
    logic [W-1:0]   w_expected;

    // Reference result computed straight from the op meaning, independent of the control-bit decode
    always_comb begin
        w_expected = '0;
        case (int'(r_op))
            0:       w_expected = '0;
            1:       w_expected = W'(1);
            2:       w_expected = '1;
            3:       w_expected = r_x;
            4:       w_expected = r_y;
            5:       w_expected = ~r_x;
            6:       w_expected = ~r_y;
            7:       w_expected = W'(0) - r_x;
            8:       w_expected = W'(0) - r_y;
            9:       w_expected = r_x + W'(1);
            10:      w_expected = r_y + W'(1);
            11:      w_expected = r_x - W'(1);
            12:      w_expected = r_y - W'(1);
            13:      w_expected = r_x + r_y;
            14:      w_expected = r_x - r_y;
            15:      w_expected = r_y - r_x;
            16:      w_expected = r_x & r_y;
            17:      w_expected = r_x | r_y;
            default: w_expected = '0;
        endcase
    end

    assign w_chk_err = (alu_out != w_expected) | (alu_zr != (w_expected == '0)) | (alu_ng != w_expected[W-1]);

    // Keep the op for the checker; only legal ops reach EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_op <= '0;
        else if (r_state == S_IDLE && bus.req_valid && w_legal)
            r_op <= bus.req_op;
    end
`else
    assign w_chk_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next state and handshake outputs
    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid)
                    w_next = w_legal ? S_EXEC : S_RESP;
            end
            S_EXEC: w_next = S_RESP;
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand/control latch on accept, result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_jmp      <= '0;
            r_ctl      <= '0;
            r_rsp_data <= '0;
            r_rsp_zr   <= 1'b0;
            r_rsp_ng   <= 1'b0;
            r_rsp_jump <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_legal) begin
                            // ALU drive only changes for ops that will execute
                            r_x   <= bus.req_x;
                            r_y   <= bus.req_y;
                            r_jmp <= bus.req_jmp;
                            r_ctl <= f_decode(bus.req_op);
                        end else begin
                            r_rsp_data <= '0;
                            r_rsp_zr   <= 1'b0;
                            r_rsp_ng   <= 1'b0;
                            r_rsp_jump <= 1'b0;
                            r_rsp_err  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_data <= alu_out;
                    r_rsp_zr   <= alu_zr;
                    r_rsp_ng   <= alu_ng;
                    r_rsp_jump <= w_jump;
                    r_rsp_err  <= w_chk_err;
                end
                default: ;
            endcase
        end
    end

    assign alu_x  = r_x;
    assign alu_y  = r_y;
    assign alu_zx = r_ctl[5];
    assign alu_nx = r_ctl[4];
    assign alu_zy = r_ctl[3];
    assign alu_ny = r_ctl[2];
    assign alu_f  = r_ctl[1];
    assign alu_no = r_ctl[0];

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zr    = r_rsp_zr;
    assign bus.rsp_ng    = r_rsp_ng;
    assign bus.rsp_jump  = r_rsp_jump;
    assign bus.rsp_err   = r_rsp_err;

endmodule
